// File: rtl/gb_oam_scan_if.sv
// Bus bundle for the OAM scan stage: scan control, OAM read port and
// line-buffer read port. The scanner takes the master side; the PPU
// (OAM RAM, mode sequencer and object fetcher) takes the slave side.
interface gb_oam_scan_if #(
  parameter int NUM_OAM  = 40,
  parameter int MAX_OBJS = 10
);
  localparam int AW = $clog2(NUM_OAM);
  localparam int CW = $clog2(MAX_OBJS + 1);

  logic          scan_start;
  logic [7:0]    ly;
  logic          obj_size;
  logic          dma_active;
  logic          oam_rd_en;
  logic [AW-1:0] oam_rd_addr;
  logic [31:0]   oam_rd_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] obj_count;
  logic [CW-1:0] buf_rd_idx;
  logic [AW+31:0] buf_rd_data;

  modport master (
    input  scan_start, ly, obj_size, dma_active, oam_rd_data, buf_rd_idx,
    output oam_rd_en, oam_rd_addr, busy, done, obj_count, buf_rd_data
  );

  modport slave (
    output scan_start, ly, obj_size, dma_active, oam_rd_data, buf_rd_idx,
    input  oam_rd_en, oam_rd_addr, busy, done, obj_count, buf_rd_data
  );
endinterface

// File: rtl/gb_oam_scan.sv
// GameBoy PPU mode-2 object selection. Walks every OAM entry at two
// T-cycles per entry (read, then evaluate) and keeps the first MAX_OBJS
// entries that overlap the latched line, in OAM order, in a small line
// buffer that the mode-3 object fetcher reads combinationally.
module gb_oam_scan #(
  parameter int NUM_OAM  = 40,
  parameter int MAX_OBJS = 10
) (
  input  logic          clk_t,
  input  logic          reset,
  gb_oam_scan_if.master bus
);
  localparam int AW   = $clog2(NUM_OAM);
  localparam int CW   = $clog2(MAX_OBJS + 1);
  localparam int CNTW = AW + 1;
  localparam int DW   = AW + 32;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(2 * NUM_OAM - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(MAX_OBJS);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [7:0]      ly_q, ly_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic [DW-1:0]   slots [MAX_OBJS];

  logic [8:0] lyp;
  logic [8:0] y9;
  logic [8:0] y_end;
  logic       visible;
  logic       eval;
  logic       store;

  // Vertical overlap test in 9 bits so Y+height never wraps.
  assign lyp     = {1'b0, ly_q} + 9'd16;
  assign y9      = {1'b0, bus.oam_rd_data[7:0]};
  assign y_end   = y9 + (bus.obj_size ? 9'd16 : 9'd8);
  assign visible = (lyp >= y9) && (lyp < y_end) && !bus.dma_active;

  // Odd counts are the cycles where the RAM data for entry cnt[6:1] is valid.
  assign eval  = (state_q == SCAN) && cnt_q[0];
  assign store = eval && visible && !bus.scan_start && (count_q < CNT_FULL);

  // Next-state logic: a start pulse always wins and restarts the walk.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ly_d    = ly_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (bus.scan_start) begin
      state_d = SCAN;
      cnt_d   = '0;
      ly_d    = bus.ly;
      count_d = '0;
    end else if (state_q == SCAN) begin
      if (store) count_d = count_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_t or negedge reset) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ly_q    <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ly_q    <= ly_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Line buffer: append the current entry with its OAM index on a store.
  always_ff @(posedge clk_t or negedge reset) begin
    // NOTE: the slots are cleared on reset so nothing stale is ever readable after power-up; that keeps them in flops rather than a RAM macro.
    if (!reset) begin
      for (int i = 0; i < MAX_OBJS; i++) slots[i] <= '0;
    end else if (store) begin
      slots[count_q] <= {cnt_q[CNTW-1:1], bus.oam_rd_data};
    end
  end

  assign bus.busy        = (state_q == SCAN);
  assign bus.done        = done_q;
  assign bus.obj_count   = count_q;
  assign bus.oam_rd_en   = (state_q == SCAN) && !cnt_q[0];
  assign bus.oam_rd_addr = cnt_q[CNTW-1:1];

  // Zero-latency buffer read; unfilled slots read as zero.
  always_comb begin
    bus.buf_rd_data = '0;
    for (int i = 0; i < MAX_OBJS; i++) begin
      if ((bus.buf_rd_idx == CW'(i)) && (CW'(i) < count_q)) bus.buf_rd_data = slots[i];
    end
  end
endmodule

// File: tb/tb_gb_oam_scan.sv
// Self-checking bench for gb_oam_scan: directed scan table, hand-written
// restart / done-coincident-start / mid-scan reset sequences, and random
// scans checked against a list-building reference model.
module tb_gb_oam_scan;
  localparam int NUM_OAM  = 40;
  localparam int MAX_OBJS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gb_oam_scan_if #(.NUM_OAM(NUM_OAM), .MAX_OBJS(MAX_OBJS)) bus ();

  gb_oam_scan #(.NUM_OAM(NUM_OAM), .MAX_OBJS(MAX_OBJS)) u_dut (
    .clk_t (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // OAM contents and a synchronous-read RAM model.
  logic [31:0] oam [NUM_OAM];
  initial bus.oam_rd_data = '0;
  always @(posedge clk) if (bus.oam_rd_en) bus.oam_rd_data <= oam[bus.oam_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string           name;
    logic [7:0]      ly;
    logic            size;
    logic [7:0]      y_all;
    logic [39:0]     dma;
    int              n_ovr;
    logic [2:0][5:0] o_idx;
    logic [2:0][7:0] o_y;
    logic [2:0][7:0] o_x;
    int              exp_n;
    logic [9:0][5:0] exp_idx;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t vdef(input string nm, input logic [7:0] l, input logic sz, input logic [7:0] ya);
    vec_t v;
    v.name = nm; v.ly = l; v.size = sz; v.y_all = ya; v.dma = '0;
    v.n_ovr = 0; v.o_idx = '0; v.o_y = '0; v.o_x = '0;
    v.exp_n = 0; v.exp_idx = '0;
    return v;
  endfunction

  // Default entry n: flags=n, tile=A0+n, X=8+n, Y=y_all.
  task automatic load_vec(input vec_t v);
    for (int n = 0; n < NUM_OAM; n++) oam[n] = {8'(n), 8'(8'hA0 + n), 8'(8 + n), v.y_all};
    for (int j = 0; j < v.n_ovr; j++) oam[v.o_idx[j]][15:0] = {v.o_x[j], v.o_y[j]};
  endtask

  // Reference: first MAX_OBJS entries, in OAM order, whose rows cover the line.
  task automatic model(input logic [7:0] l, input logic sz, input logic [39:0] mask);
    int lyp, h, y;
    exp_q.delete();
    lyp = int'(l) + 16;
    h   = sz ? 16 : 8;
    for (int n = 0; n < NUM_OAM; n++) begin
      y = int'(oam[n][7:0]);
      if (!mask[n] && lyp >= y && lyp < y + h && exp_q.size() < MAX_OBJS) exp_q.push_back(n);
    end
  endtask

  // One complete scan; mask[n] drives dma_active on entry n's evaluation cycle.
  task automatic run_scan(input string tag, input logic [7:0] l, input logic sz, input logic [39:0] mask);
    int  busy_n, errs, done_at, done_n;
    logic exp_en;
    @(negedge clk);
    bus.scan_start = 1'b1; bus.ly = l; bus.obj_size = sz; bus.dma_active = 1'($urandom);
    busy_n = 0; errs = 0; done_at = -1; done_n = 0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      bus.scan_start = 1'b0;
      bus.ly = 8'($urandom);
      if (bus.busy === 1'b1) busy_n++;
      if (bus.busy !== (k <= 80)) errs++;
      exp_en = (k <= 80) && (k % 2 == 1);
      if (bus.oam_rd_en !== exp_en) errs++;
      if (exp_en && bus.oam_rd_addr !== 6'((k - 1) / 2)) errs++;
      if (bus.done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k <= 80 && k % 2 == 0) bus.dma_active = mask[(k - 2) / 2];
      else bus.dma_active = 1'($urandom);
    end
    bus.dma_active = 1'b0;
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd80);
    check({tag, "_read_pattern_errs"}, 64'(errs), 64'd0);
    check({tag, "_done_cycle"}, 64'(done_at), 64'd81);
    check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
  endtask

  // Compare obj_count and every buffer index against exp_q.
  task automatic check_buffer(input string tag);
    logic [37:0] exp;
    check({tag, "_obj_count"}, 64'(bus.obj_count), 64'(exp_q.size()));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.buf_rd_idx = 4'(i);
      #1;
      exp = (i < exp_q.size()) ? {6'(exp_q[i]), oam[exp_q[i]]} : 38'd0;
      check($sformatf("%s_slot%0d", tag, i), 64'(bus.buf_rd_data), 64'(exp));
    end
  endtask

  task automatic fill_all_visible();
    for (int n = 0; n < NUM_OAM; n++) oam[n] = {8'(n), 8'(8'hA0 + n), 8'(8 + n), 8'd16};
  endtask

  task automatic seq_restart();
    int dn, done_at, busy_n;
    fill_all_visible();
    @(negedge clk);
    bus.scan_start = 1'b1; bus.ly = 8'd0; bus.obj_size = 1'b0; bus.dma_active = 1'b0;
    @(negedge clk);
    bus.scan_start = 1'b0;
    dn = 0;
    repeat (29) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("restart_pre_count", 64'(bus.obj_count), 64'd10);
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    check("restart_count_cleared", 64'(bus.obj_count), 64'd0);
    done_at = -1; busy_n = 0;
    for (int k = 1; k <= 81; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        dn++;
        if (done_at < 0) done_at = k;
      end
    end
    check("restart_done_cycle", 64'(done_at), 64'd81);
    check("restart_done_pulses", 64'(dn), 64'd1);
    check("restart_busy_cycles", 64'(busy_n), 64'd80);
    // Start pulse in the same cycle as done restarts normally.
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    check("coinc_busy", 64'(bus.busy), 64'd1);
    check("coinc_no_done", 64'(bus.done), 64'd0);
    check("coinc_count_cleared", 64'(bus.obj_count), 64'd0);
    done_at = -1;
    for (int k = 2; k <= 90; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 && done_at < 0) done_at = k;
    end
    check("coinc_done_cycle", 64'(done_at), 64'd81);
    check("coinc_final_count", 64'(bus.obj_count), 64'd10);
  endtask

  task automatic seq_reset();
    int errs;
    fill_all_visible();
    @(negedge clk);
    bus.scan_start = 1'b1; bus.ly = 8'd0; bus.obj_size = 1'b0;
    @(negedge clk);
    bus.scan_start = 1'b0;
    repeat (39) @(negedge clk);
    check("mid_reset_pre_count", 64'(bus.obj_count), 64'd10);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", 64'(bus.busy), 64'd0);
    check("mid_reset_done", 64'(bus.done), 64'd0);
    check("mid_reset_count", 64'(bus.obj_count), 64'd0);
    check("mid_reset_rd_en", 64'(bus.oam_rd_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.oam_rd_en !== 1'b0 || bus.done !== 1'b0 || bus.obj_count !== 4'd0) errs++;
    end
    check("post_reset_idle_errs", 64'(errs), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  l;
    logic        sz;
    logic [39:0] mask;

    bus.scan_start = 1'b0; bus.ly = '0; bus.obj_size = 1'b0;
    bus.dma_active = 1'b0; bus.buf_rd_idx = '0;

    // Directed scan table.
    vecs[0] = vdef("all_hidden", 8'd0, 1'b0, 8'd0);

    vecs[1] = vdef("vbound_h8", 8'd10, 1'b0, 8'd0);
    vecs[1].n_ovr = 3;
    vecs[1].o_idx[0] = 6'd3; vecs[1].o_y[0] = 8'd26; vecs[1].o_x[0] = 8'd11;
    vecs[1].o_idx[1] = 6'd7; vecs[1].o_y[1] = 8'd19; vecs[1].o_x[1] = 8'd15;
    vecs[1].o_idx[2] = 6'd5; vecs[1].o_y[2] = 8'd18; vecs[1].o_x[2] = 8'd13;
    vecs[1].exp_n = 2; vecs[1].exp_idx[0] = 6'd3; vecs[1].exp_idx[1] = 6'd7;

    vecs[2] = vecs[1];
    vecs[2].name = "vbound_h16"; vecs[2].size = 1'b1;
    vecs[2].exp_n = 3;
    vecs[2].exp_idx[0] = 6'd3; vecs[2].exp_idx[1] = 6'd5; vecs[2].exp_idx[2] = 6'd7;

    vecs[3] = vdef("overflow", 8'd0, 1'b0, 8'd16);
    vecs[3].exp_n = 10;
    for (int i = 0; i < 10; i++) vecs[3].exp_idx[i] = 6'(i);

    vecs[4] = vdef("x_ignored", 8'd0, 1'b0, 8'd0);
    vecs[4].n_ovr = 2;
    vecs[4].o_idx[0] = 6'd0; vecs[4].o_y[0] = 8'd16; vecs[4].o_x[0] = 8'd0;
    vecs[4].o_idx[1] = 6'd1; vecs[4].o_y[1] = 8'd16; vecs[4].o_x[1] = 8'd200;
    vecs[4].exp_n = 2; vecs[4].exp_idx[0] = 6'd0; vecs[4].exp_idx[1] = 6'd1;

    vecs[5] = vdef("dma_entry2", 8'd0, 1'b0, 8'd0);
    vecs[5].dma = 40'h4;
    vecs[5].n_ovr = 3;
    vecs[5].o_idx[0] = 6'd1; vecs[5].o_y[0] = 8'd16; vecs[5].o_x[0] = 8'd9;
    vecs[5].o_idx[1] = 6'd2; vecs[5].o_y[1] = 8'd16; vecs[5].o_x[1] = 8'd10;
    vecs[5].o_idx[2] = 6'd3; vecs[5].o_y[2] = 8'd16; vecs[5].o_x[2] = 8'd11;
    vecs[5].exp_n = 2; vecs[5].exp_idx[0] = 6'd1; vecs[5].exp_idx[1] = 6'd3;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_count", 64'(bus.obj_count), 64'd0);
    check("reset_rd_en", 64'(bus.oam_rd_en), 64'd0);
    check("reset_rd_addr", 64'(bus.oam_rd_addr), 64'd0);
    check("reset_buf_data", 64'(bus.buf_rd_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy_after_release", 64'(bus.busy), 64'd0);

    foreach (vecs[v]) begin
      load_vec(vecs[v]);
      run_scan(vecs[v].name, vecs[v].ly, vecs[v].size, vecs[v].dma);
      exp_q.delete();
      for (int i = 0; i < vecs[v].exp_n; i++) exp_q.push_back(int'(vecs[v].exp_idx[i]));
      check_buffer(vecs[v].name);
    end

    seq_restart();
    seq_reset();

    // Random scans against the reference model.
    for (int r = 0; r < 25; r++) begin
      l  = ($urandom_range(0, 7) == 0) ? 8'(255 - $urandom_range(0, 20)) : 8'($urandom_range(0, 153));
      sz = 1'($urandom);
      for (int n = 0; n < NUM_OAM; n++) begin
        oam[n][31:8] = 24'($urandom);
        if ($urandom_range(0, 1) == 0) oam[n][7:0] = 8'($urandom);
        else oam[n][7:0] = 8'(int'(l) + 16 - $urandom_range(0, 20));
      end
      mask = '0;
      for (int n = 0; n < NUM_OAM; n++) mask[n] = ($urandom_range(0, 7) == 0);
      model(l, sz, mask);
      run_scan($sformatf("rand%0d", r), l, sz, mask);
      check_buffer($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gb_oam_scan.md
# gb_oam_scan

Mode 2 (OAM_SCAN) object-selection stage of the GameBoy PPU. On each scanline it walks all 40 OAM entries at 2 T-cycles per entry, 80 cycles total. It selects up to 10 objects that vertically overlap the current line, in OAM order. The selected objects go into an internal line buffer that the downstream object fetcher in `gb_ppu` reads during mode 3.

## Interface
Parameters:
- `NUM_OAM`, default 40: number of OAM entries scanned.
- `MAX_OBJS`, default 10: line buffer capacity.

Ports (widths are for the default parameters):
- `clk_t` input 1: T-clock. Single clock domain.
- `reset` input 1: asynchronous, active-low reset. Reset is asserted while the pin is 0.
- `scan_start` input 1: one-cycle pulse at the start of mode 2.
- `ly` input 8: current line. Latched on `scan_start`.
- `obj_size` input 1: object height, 0 = 8 lines, 1 = 16 lines. Sampled live at each evaluation.
- `dma_active` input 1: OAM DMA in progress.
- `oam_rd_en` output 1: OAM read strobe.
- `oam_rd_addr` output 6: OAM entry index.
- `oam_rd_data` input 32: entry fields {flags[31:24], tile[23:16], X[15:8], Y[7:0]}. Synchronous RAM, valid 1 cycle after the cycle with `oam_rd_en`=1.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle pulse when the scan completes.
- `obj_count` output 4: number of objects stored, 0..10.
- `buf_rd_idx` input 4: line buffer read index.
- `buf_rd_data` output 38: combinational read of the selected entry, {oam_idx[37:32], flags, tile, X, Y}.

## Operation
- States: IDLE and SCAN. A 7-bit counter `cnt` runs 0..79 in SCAN.
- IDLE → SCAN on `scan_start`. On the same edge: `ly` is latched, `cnt`=0, `obj_count`=0.
- Read issue in SCAN: `oam_rd_addr`=`cnt[6:1]`, `oam_rd_en`=~`cnt[0]`. Outputs are driven from registered state.
- Evaluation happens on the edge that ends an odd-`cnt` cycle, using `oam_rd_data`:
  - `lyp` = {1'b0,`ly`}+16 and `y9` = {1'b0,Y}, both 9-bit. No overflow is possible (max value 271).
  - `h` = 16 if `obj_size` else 8.
  - The entry is visible iff `lyp` ≥ `y9` and `lyp` < `y9`+`h`.
  - X is ignored. X=0 and X≥168 still count as visible and consume a slot.
  - If `dma_active`=1 on the evaluation cycle, the entry is treated as not visible.
- On a visible entry with `obj_count` < `MAX_OBJS`: write the entry to slot `obj_count` with oam_idx=`cnt[6:1]`, then increment `obj_count`.
- Buffer full: remaining entries are still read and evaluated, but nothing is stored. The 80-cycle duration is fixed.
- On the edge ending `cnt`=79: SCAN → IDLE and `done` is asserted for the next cycle.
- Buffer contents and `obj_count` hold until the next `scan_start`.
- `buf_rd_data` returns 0 when `buf_rd_idx` ≥ `obj_count`.
- `scan_start` while in SCAN: abort and restart. `cnt`=0, `obj_count`=0, `ly` re-latched. No `done` is produced for the aborted scan.
- `scan_start` in the same cycle as `done`: restart normally.
- Reset (asynchronous, any state): state=IDLE, `cnt`=0, `busy`=0, `done`=0, `obj_count`=0, `oam_rd_en`=0, `oam_rd_addr`=0, all buffer slots cleared to 0.

## Timing
- `scan_start` sampled at edge E0: `busy`=1 for cycles E0+1 … E0+80 (exactly 80 cycles).
- `done`=1 in cycle E0+81. `busy`=0 from that cycle.
- Entry n:
  - read issued in cycle E0+1+2n;
  - data valid in cycle E0+2+2n;
  - stored at the end of cycle E0+2+2n.
- `obj_count` increments are visible 1 cycle after each store.
- The buffer read path is combinational and has 0-cycle latency.

## Test plan
- **All entries hidden:** all Y=0, `ly`=0, `obj_size`=0 → `done` at E0+81, `obj_count`=0, every `buf_rd_data`=0.
- **Vertical boundary:** `ly`=10, `obj_size`=0.
  - Entry 3 Y=26 and entry 7 Y=19 → visible; `obj_count`=2, slot0 oam_idx=3, slot1 oam_idx=7.
  - Entry 5 Y=18 → not visible (lyp 26 ≥ Y+8).
  - With `obj_size`=1, entry 5 also becomes visible → `obj_count`=3, in OAM order 3,5,7.
- **Buffer overflow:** all 40 entries Y=16, `ly`=0 → `obj_count`=10, slots hold oam_idx 0..9, `busy` still lasts 80 cycles.
- **X ignored:** entry 0 Y=16 X=0, entry 1 Y=16 X=200, `ly`=0 → both stored, `obj_count`=2.
- **DMA and restart:**
  - `dma_active`=1 on entry 2's evaluation cycle with entry 2 visible → entry 2 not stored.
  - Second `scan_start` at E0+30 → `obj_count` clears, `done` at (E0+30)+81 only.
- **Mid-scan reset:** reset pulled low at E0+40 → `busy`, `done`, `obj_count`, `oam_rd_en` go to 0 immediately; after release, stays in IDLE until the next `scan_start`.
